// File: rtl/integrator.sv
// Boxcar integrator for the qubit readout chain: sums LANES parallel I/Q samples per
// clock over a programmable window and presents the 32-bit totals with a one-cycle strobe.
module integrator #(
    parameter int LANES    = 5,
    parameter int SAMPLE_W = 16,
    parameter int ACC_W    = 32,
    parameter int LEN_W    = 11
) (
    input  logic                      clk100,
    input  logic                      reset,
    input  logic                      start,
    input  logic [LEN_W-1:0]          sample_length,
    input  logic [LANES*SAMPLE_W-1:0] data_i_rot,
    input  logic [LANES*SAMPLE_W-1:0] data_q_rot,
    output logic                      iq_valid,
    output logic [ACC_W-1:0]          i_val,
    output logic [ACC_W-1:0]          q_val
);

    localparam int LSUM_W = SAMPLE_W + $clog2(LANES);

    typedef enum logic [1:0] {
        IDLE,
        INTEGRATE,
        FLUSH,
        DONE
    } stateT;

    stateT             r_state;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_count;
    logic              r_sumValid;
    logic [LSUM_W-1:0] r_laneSumI;
    logic [LSUM_W-1:0] r_laneSumQ;
    logic [ACC_W-1:0]  r_accI;
    logic [ACC_W-1:0]  r_accQ;

    logic [LSUM_W-1:0] w_laneSumI;
    logic [LSUM_W-1:0] w_laneSumQ;
    logic [ACC_W-1:0]  w_extI;
    logic [ACC_W-1:0]  w_extQ;

    // Stage 1: sign-extend each lane and add them into one lane sum per channel.
    always_comb begin
        w_laneSumI = '0;
        w_laneSumQ = '0;
        for (int k = 0; k < LANES; k++) begin
            w_laneSumI = w_laneSumI + {{(LSUM_W-SAMPLE_W){data_i_rot[k*SAMPLE_W+SAMPLE_W-1]}},
                                       data_i_rot[k*SAMPLE_W +: SAMPLE_W]};
            w_laneSumQ = w_laneSumQ + {{(LSUM_W-SAMPLE_W){data_q_rot[k*SAMPLE_W+SAMPLE_W-1]}},
                                       data_q_rot[k*SAMPLE_W +: SAMPLE_W]};
        end
    end

    assign w_extI = {{(ACC_W-LSUM_W){r_laneSumI[LSUM_W-1]}}, r_laneSumI};
    assign w_extQ = {{(ACC_W-LSUM_W){r_laneSumQ[LSUM_W-1]}}, r_laneSumQ};

    // r_sumValid marks that r_laneSum holds a sample of the current window, so the
    // stale lane sum left over from before the window is never accumulated.
    always_ff @(posedge clk100) begin
        if (reset) begin
            r_state    <= IDLE;
            r_len      <= '0;
            r_count    <= '0;
            r_sumValid <= 1'b0;
            r_laneSumI <= '0;
            r_laneSumQ <= '0;
            r_accI     <= '0;
            r_accQ     <= '0;
            i_val      <= '0;
            q_val      <= '0;
            iq_valid   <= 1'b0;
        end else begin
            iq_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start && (sample_length != '0)) begin
                        r_len      <= sample_length;
                        r_count    <= '0;
                        r_accI     <= '0;
                        r_accQ     <= '0;
                        r_sumValid <= 1'b0;
                        r_state    <= INTEGRATE;
                    end
                end
                INTEGRATE: begin
                    r_laneSumI <= w_laneSumI;
                    r_laneSumQ <= w_laneSumQ;
                    r_sumValid <= 1'b1;
                    if (r_sumValid) begin
                        r_accI <= r_accI + w_extI;
                        r_accQ <= r_accQ + w_extQ;
                    end
                    if (r_count == (r_len - LEN_W'(1))) begin
                        r_state <= FLUSH;
                    end else begin
                        r_count <= r_count + LEN_W'(1);
                    end
                end
                FLUSH: begin
                    r_accI     <= r_accI + w_extI;
                    r_accQ     <= r_accQ + w_extQ;
                    r_sumValid <= 1'b0;
                    r_state    <= DONE;
                end
                DONE: begin
                    i_val    <= r_accI;
                    q_val    <= r_accQ;
                    iq_valid <= 1'b1;
                    r_state  <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_integrator.sv
// Self-checking bench for integrator: directed and random windows compared against
// sums the bench computes from the samples it drives.
module tb_integrator;

    logic        clk100 = 1'b0;
    logic        reset;
    logic        start;
    logic [10:0] sample_length;
    logic [79:0] data_i_rot;
    logic [79:0] data_q_rot;
    logic        iq_valid;
    logic [31:0] i_val;
    logic [31:0] q_val;

    int errorCount = 0;
    int checkCount = 0;

    logic signed [15:0] laneI [5];
    logic signed [15:0] laneQ [5];
    int lastI, lastQ;
    int rampSumI [0:4100];
    int rampSumQ [0:4100];

    integrator dut (
        .clk100        (clk100),
        .reset         (reset),
        .start         (start),
        .sample_length (sample_length),
        .data_i_rot    (data_i_rot),
        .data_q_rot    (data_q_rot),
        .iq_valid      (iq_valid),
        .i_val         (i_val),
        .q_val         (q_val)
    );

    always #5 clk100 = ~clk100;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic s, input int len);
        start         = s;
        sample_length = 11'(len);
        for (int k = 0; k < 5; k++) begin
            data_i_rot[k*16 +: 16] = laneI[k];
            data_q_rot[k*16 +: 16] = laneQ[k];
        end
    endtask

    task automatic fillRandom();
        for (int k = 0; k < 5; k++) begin
            laneI[k] = 16'($urandom);
            laneQ[k] = 16'($urandom);
        end
    endtask

    task automatic fillConst(input int a, input int b);
        for (int k = 0; k < 5; k++) begin
            laneI[k] = 16'(a);
            laneQ[k] = 16'(b);
        end
    endtask

    // Start is seen at edge 0; samples for edges 1..len count, and the strobe is
    // registered on edge len+2 so downstream sees it in cycle len+3.
    task automatic runWindow(input string name, input int len, input bit useRandom,
                             input int cI, input int cQ);
        int expI, expQ, validAt, pulses, capI, capQ;
        expI = 0; expQ = 0; validAt = -1; pulses = 0; capI = 0; capQ = 0;
        @(negedge clk100);
        fillRandom();
        applyStimulus(1'b1, len);
        for (int m = 0; m <= len + 6; m++) begin
            @(negedge clk100);
            if (iq_valid) begin
                pulses++;
                if (validAt < 0) begin
                    validAt = m;
                    capI = $signed(i_val);
                    capQ = $signed(q_val);
                end
            end
            if (m + 1 <= len) begin
                if (useRandom) fillRandom();
                else fillConst(cI, cQ);
                for (int k = 0; k < 5; k++) begin
                    expI += int'(laneI[k]);
                    expQ += int'(laneQ[k]);
                end
            end else begin
                fillRandom();
            end
            applyStimulus(1'b0, len);
        end
        checkOutput({name, "_latency"}, validAt, len + 2);
        checkOutput({name, "_pulses"}, pulses, 1);
        checkOutput({name, "_iVal"}, capI, expI);
        checkOutput({name, "_qVal"}, capQ, expQ);
        checkOutput({name, "_iHold"}, $signed(i_val), expI);
        lastI = capI;
        lastQ = capQ;
    endtask

    task automatic idleWatch(input string name, input int cycles, input logic s, input int len);
        int pulses;
        pulses = 0;
        for (int m = 0; m < cycles; m++) begin
            @(negedge clk100);
            if (iq_valid) pulses++;
            fillRandom();
            applyStimulus(s, len);
        end
        checkOutput({name, "_pulses"}, pulses, 0);
        checkOutput({name, "_iVal"}, $signed(i_val), 0);
        checkOutput({name, "_qVal"}, $signed(q_val), 0);
    endtask

    initial begin
        #10000000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int expI, expQ, w;
        bit expV;
        reset = 1'b1;
        fillRandom();
        applyStimulus(1'b1, 5);
        repeat (3) @(negedge clk100);
        checkOutput("rst_iqValid", int'(iq_valid), 0);
        checkOutput("rst_iVal", $signed(i_val), 0);
        checkOutput("rst_qVal", $signed(q_val), 0);
        reset = 1'b0;
        applyStimulus(1'b0, 5);

        idleWatch("startLow", 40, 1'b0, 8);
        idleWatch("lenZero", 40, 1'b1, 0);
        applyStimulus(1'b0, 0);

        runWindow("plusOne", 4, 1'b0, 1, 2);
        checkOutput("plusOne_i20", lastI, 20);
        checkOutput("plusOne_q40", lastQ, 40);
        runWindow("minusOne", 10, 1'b0, -1, -1);
        checkOutput("minusOne_i", lastI, -50);
        runWindow("maxPos", 2047, 1'b0, 32767, 32767);
        checkOutput("maxPos_i", lastI, 335370245);
        runWindow("maxNeg", 2047, 1'b0, -32768, -32768);
        checkOutput("maxNeg_i", lastI, -335380480);

        for (int r = 0; r < 4; r++) begin
            runWindow("random", $urandom_range(1, 50), 1'b1, 0, 0);
        end

        // Ramp with start held: windows begin at edges 0 and 2003, start drops before 4006.
        @(negedge clk100);
        for (int k = 0; k < 5; k++) begin
            laneI[k] = 16'(0);
            laneQ[k] = 16'(0);
        end
        rampSumI[0] = 0;
        rampSumQ[0] = 0;
        applyStimulus(1'b1, 2000);
        for (int m = 0; m <= 4012; m++) begin
            @(negedge clk100);
            expV = ((m % 2003) == 2002);
            if (expV || iq_valid) begin
                checkOutput("ramp_valid", int'(iq_valid), int'(expV));
                if (expV) begin
                    w = (m / 2003) * 2003;
                    expI = 0;
                    expQ = 0;
                    for (int e = w + 1; e <= w + 2000; e++) begin
                        expI += rampSumI[e];
                        expQ += rampSumQ[e];
                    end
                    checkOutput("ramp_iVal", $signed(i_val), expI);
                    checkOutput("ramp_qVal", $signed(q_val), expQ);
                end
            end
            rampSumI[m+1] = 0;
            rampSumQ[m+1] = 0;
            for (int k = 0; k < 5; k++) begin
                laneI[k] = 16'(k * (m + 1));
                laneQ[k] = 16'(-(k * (m + 1)));
                rampSumI[m+1] += int'(laneI[k]);
                rampSumQ[m+1] += int'(laneQ[k]);
            end
            applyStimulus((m + 1) < 4006, 2000);
        end

        // Reset after 100 samples of a 2000-cycle window drops the partial result.
        @(negedge clk100);
        fillRandom();
        applyStimulus(1'b1, 2000);
        for (int m = 0; m < 100; m++) begin
            @(negedge clk100);
            fillRandom();
            applyStimulus(1'b0, 2000);
        end
        reset = 1'b1;
        @(negedge clk100);
        reset = 1'b0;
        idleWatch("midReset", 2100, 1'b0, 2000);

        runWindow("single", 1, 1'b1, 0, 0);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
